// File: rtl/cpu_types_pkg.sv
// Types shared by the memory controller, the caches and the RAM model.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Progress reported by the RAM back to the requester.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read, never reset.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // Commit a write at the edge ending the ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side RAM responder: fixed-latency single-word read/write with
// FREE/BUSY/ACCESS/ERROR progress reporting.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int LAT   = 2,
  parameter int CNT_W = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int               AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0]      lat_addr_q, lat_addr_d;
  logic             lat_op_q, lat_op_d;
  logic             lat_v_q, lat_v_d;

  logic [29:0] idx;
  logic [1:0]  unused_lo;
  logic        in_range;
  logic        match;
  logic        we;
  word_t       rdata;

  assign idx       = ramaddr[31:2];
  assign unused_lo = ramaddr[1:0];
  assign in_range  = (32'(idx) < 32'(DEPTH));
  // The latched request is still the one on the bus: same word, same op.
  assign match     = lat_v_q & (lat_addr_q == idx) & (lat_op_q == ramWEN);

  // Status decode, highest priority first.
  always_comb begin
    ramstate = BUSY;
    if (RST)                              ramstate = BUSY;
    else if (!ramREN && !ramWEN)          ramstate = FREE;
    else if (ramREN && ramWEN)            ramstate = ERROR;
    else if (!in_range)                   ramstate = ERROR;
    else if (LAT == 0 || (match && cnt_q >= LAT_C)) ramstate = ACCESS;
    else                                  ramstate = BUSY;
  end

  // Next-state for the latency counter and request latch.
  always_comb begin
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_op_d   = lat_op_q;
    lat_v_d    = lat_v_q;
    unique case (ramstate)
      FREE, ERROR: begin
        cnt_d   = '0;
        lat_v_d = 1'b0;
      end
      BUSY: begin
        if (!match) begin
          // New or changed request: abandon the old one and restart the count.
          lat_addr_d = idx;
          lat_op_d   = ramWEN;
          lat_v_d    = 1'b1;
          cnt_d      = CNT_W'(1);
        end else if (cnt_q < LAT_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        // A request still held next cycle is a fresh access.
        cnt_d   = '0;
        lat_v_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Latency state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_op_q   <= 1'b0;
      lat_v_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      lat_op_q   <= lat_op_d;
      lat_v_q    <= lat_v_d;
    end
  end

  assign we = (ramstate == ACCESS) & ramWEN;

  ram_array #(.DEPTH(DEPTH), .AW(AW)) u_arr (
    .CLK   (CLK),
    .we    (we),
    .waddr (idx[AW-1:0]),
    .wdata (ramstore),
    .raddr (idx[AW-1:0]),
    .rdata (rdata)
  );

  // Data only leaves on a read ACCESS; no write-to-read bypass.
  assign ramload = (ramstate == ACCESS && ramREN) ? rdata : 32'h0;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a LAT=2 instance and a LAT=0 instance.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      ren, wen, zren, zwen;
  word_t     addr, store, zaddr, zstore;
  word_t     load, zload;
  ramstate_t state, zstate;

  int errors = 0;
  int checks = 0;

  word_t model [logic [29:0]];
  word_t sbq [$];

  always #5 clk = ~clk;

  ram_responder #(.DEPTH(16384), .LAT(2), .CNT_W(4)) d2 (
    .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(store), .ramload(load), .ramstate(state)
  );

  ram_responder #(.DEPTH(16384), .LAT(0), .CNT_W(4)) d0 (
    .CLK(clk), .RST(rst), .ramREN(zren), .ramWEN(zwen),
    .ramaddr(zaddr), .ramstore(zstore), .ramload(zload), .ramstate(zstate)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the LAT=2 instance and hold it until ACCESS.
  task automatic req2(input bit w, input word_t a, input word_t d, input int exp_lat,
                      input string tag);
    int n;
    word_t exp;
    ren = !w; wen = w; addr = a; store = d;
    if (!w) sbq.push_back(model[a[31:2]]);
    n = 0;
    @(negedge clk);
    while (state != ACCESS && n < 20) begin
      chk({tag, "_busy"}, 32'(state), 32'(BUSY));
      chk({tag, "_busyload"}, load, 32'h0);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (!w) begin
      exp = sbq.pop_front();
      chk({tag, "_data"}, load, exp);
    end else begin
      chk({tag, "_wload"}, load, 32'h0);
      model[a[31:2]] = d;
    end
    next_cyc();
  endtask

  // Single-cycle request on the LAT=0 instance.
  task automatic req0(input bit w, input word_t a, input word_t d, input string tag);
    zren = !w; zwen = w; zaddr = a; zstore = d;
    if (!w) sbq.push_back(model[a[31:2]]);
    @(negedge clk);
    chk({tag, "_state"}, 32'(zstate), 32'(ACCESS));
    if (!w) chk({tag, "_data"}, zload, sbq.pop_front());
    else    model[a[31:2]] = d;
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    ren = 0; wen = 0; addr = 0; store = 0;
    zren = 0; zwen = 0; zaddr = 0; zstore = 0;

    // Reset state
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(BUSY));
    chk("rst_load", load, 32'h0);
    chk("rst_cnt", 32'(d2.cnt_q), 32'h0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_free", 32'(state), 32'(FREE));
    next_cyc();

    // 1: write then read at LAT=2
    req2(1, 32'h40, 32'hDEADBEEF, 2, "t1_w");
    ren = 0; wen = 0;
    next_cyc();
    req2(0, 32'h40, 32'h0, 2, "t1_r");
    // same read held after ACCESS pays full latency again
    req2(0, 32'h40, 32'h0, 2, "t1_rhold");

    // 2: back-to-back writes, readback, byte alias
    req2(1, 32'h100, 32'hA0A0_0100, 2, "t2_w0");
    req2(1, 32'h104, 32'hB0B0_0104, 2, "t2_w1");
    req2(0, 32'h100, 32'h0, 2, "t2_r0");
    req2(0, 32'h104, 32'h0, 2, "t2_r1");
    req2(0, 32'h102, 32'h0, 2, "t2_alias");

    // 3: address change mid-access restarts the count, abandons the old write
    req2(1, 32'h200, 32'h11111111, 2, "t3_pre");
    ren = 0; wen = 1; addr = 32'h200; store = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t3_busy0", 32'(state), 32'(BUSY));
    next_cyc();
    req2(1, 32'h300, 32'h33333333, 2, "t3_sw");
    req2(0, 32'h200, 32'h0, 2, "t3_r200");
    req2(0, 32'h300, 32'h0, 2, "t3_r300");

    // 4: errors and idle
    ren = 1; wen = 1; addr = 32'h40; store = 32'h0BAD0BAD;
    @(negedge clk);
    chk("t4_both", 32'(state), 32'(ERROR));
    chk("t4_bothload", load, 32'h0);
    next_cyc();
    ren = 1; wen = 0; addr = 32'h0001_0000;
    @(negedge clk);
    chk("t4_range", 32'(state), 32'(ERROR));
    chk("t4_rangeload", load, 32'h0);
    next_cyc();
    ren = 0; wen = 0;
    @(negedge clk);
    chk("t4_free", 32'(state), 32'(FREE));
    next_cyc();
    @(negedge clk);
    chk("t4_freecnt", 32'(d2.cnt_q), 32'h0);
    next_cyc();
    req2(0, 32'h40, 32'h0, 2, "t4_nowrite");

    // 5: reset pulsed during a BUSY write
    req2(1, 32'h500, 32'h12341234, 2, "t5_pre");
    ren = 0; wen = 1; addr = 32'h500; store = 32'h5A5A5A5A;
    @(negedge clk);
    chk("t5_busy", 32'(state), 32'(BUSY));
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rststate", 32'(state), 32'(BUSY));
    chk("t5_rstload", load, 32'h0);
    chk("t5_rstcnt", 32'(d2.cnt_q), 32'h0);
    next_cyc();
    @(negedge clk);
    chk("t5_nowrite", d2.u_arr.mem[14'h140], 32'h12341234);
    next_cyc();
    rst = 1'b0;
    req2(1, 32'h500, 32'h5A5A5A5A, 2, "t5_post");
    req2(0, 32'h500, 32'h0, 2, "t5_r500");
    req2(0, 32'h104, 32'h0, 2, "t5_persist");

    // 6: LAT=0 build
    req0(1, 32'h40, 32'hCAFEF00D, "t6_w");
    req0(0, 32'h40, 32'h0, "t6_r");
    req0(1, 32'h44, 32'h0044_0044, "t6_w2");
    req0(0, 32'h44, 32'h0, "t6_r2");
    zren = 0; zwen = 0;
    @(negedge clk);
    chk("t6_free", 32'(zstate), 32'(FREE));
    chk("t6_sbq_empty", 32'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side end of the RAM request interface driven by the bus/coherence memory controller.
- Accepts single-word read/write requests (ramREN/ramWEN, ramaddr, ramstore).
- Models a fixed access latency and reports progress on ramstate (FREE/BUSY/ACCESS/ERROR).
- Returns read data on ramload; backs the system RAM in simulation and FPGA builds.

Parameters:
- DEPTH, 16384, number of 32-bit words stored (64 KB).
- LAT, 2, cycles from a new request to ACCESS; 0 means same-cycle ACCESS.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > LAT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ramREN  in  1  read request.
- ramWEN  in  1  write request.
- ramaddr  in  32  byte address; bits [1:0] ignored, word index = ramaddr[31:2].
- ramstore  in  32  write data.
- ramload  out  32  read data.
- ramstate  out  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Registers: cnt (CNT_W bits), lat_addr (30 bits), lat_op (1 bit, 1 = write), lat_v (1 bit). All clear on RST. Memory array is not reset; contents persist across reset.
- match = lat_v & (lat_addr == ramaddr[31:2]) & (lat_op == ramWEN).
- ramstate decode (combinational, evaluated in priority order):
  - RST high -> BUSY.
  - ramREN = ramWEN = 0 -> FREE.
  - ramREN & ramWEN -> ERROR.
  - word index >= DEPTH -> ERROR.
  - LAT == 0, or (match & cnt >= LAT) -> ACCESS.
  - Otherwise -> BUSY.
- Register update on each rising edge:
  - FREE or ERROR: cnt <= 0, lat_v <= 0.
  - BUSY & !match: latch address and op, lat_v <= 1, cnt <= 1.
  - BUSY & match: cnt <= cnt + 1, saturating at LAT.
  - ACCESS: lat_v <= 0, cnt <= 0. If ramWEN, mem[index] <= ramstore.
- Latency: a request held stable from cycle 0 shows BUSY in cycles 0..LAT-1 and ACCESS in cycle LAT.
- After ACCESS, a request held unchanged is treated as a new access and pays full latency again.
- Request change mid-access: a new address or op while BUSY restarts the latency count; the old request is abandoned with no write.
- ramload:
  - ACCESS & ramREN -> mem[index].
  - All other cycles -> 32'h0.
- Read-after-write: a write commits at the edge ending its ACCESS cycle, so any later read returns the new data. There is no same-cycle bypass.
- RST asserted mid-access: counter and latch clear, no write occurs, ramload = 0. A request still held after RST deasserts starts fresh.
- No buffering: exactly one outstanding request. The requester must hold address, op and data stable until it sees ACCESS.

Decomposition:
- ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t (32-bit) belong in cpu_types_pkg. That package is shared with the memory controller and the caches.
- One sub-module: ram_array.
  - DEPTH x 32 storage.
  - Synchronous write (we, waddr, wdata).
  - Asynchronous read (raddr -> rdata).
  - No reset.
- ram_responder holds the latency FSM, counter, decode and output muxing.

Test Plan:
1. LAT=2: write 32'hDEADBEEF to 0x0000_0040 held from cycle 0 -> BUSY in cycles 0-1, ACCESS in cycle 2. Then read 0x40 -> ACCESS in cycle 2 of the read, ramload = 32'hDEADBEEF; ramload = 0 in its BUSY cycles.
2. Back-to-back writes to 0x100 then 0x104, each switching address on the ACCESS cycle -> each write gets its own 2 BUSY cycles. Readback returns both words. Byte address 0x102 aliases to 0x100.
3. Address switched from 0x200 to 0x300 after 1 BUSY cycle with ramWEN high -> count restarts, ACCESS arrives 2 cycles after the switch. mem[0x200] is unchanged.
4. ramREN=ramWEN=1 -> ERROR, no write. Address 0x0001_0000 with DEPTH=16384 -> ERROR. Idle with no request -> FREE, cnt stays 0.
5. RST pulsed during a BUSY write -> ramstate = BUSY and ramload = 0 while RST is high, no write occurs. After release the same request completes at cycle LAT. Data written before the reset is still readable.
6. LAT=0 build: read of 0x40 -> ACCESS in the same cycle with data. Write followed next cycle by a read of the same address -> new data returned.
